perf_count_reader: RTL

//  Read-out stage for the bank of 64-bit event counters. It sits directly

---
 rtl/perf_count_reader_pkg.sv | 19 +
 rtl/perf_count_reader.sv | 104 ++++++++++
 2 files changed

// File: rtl/perf_count_reader_pkg.sv
// Shared types and constants for the counter read-out stage.
//   perf_rd_state_t : read-out FSM states
//   CNT_W           : width of one event counter
//   RD_W            : width of one response beat
//   ERR_DATA        : beat payload returned for an out-of-range index
package perf_count_reader_pkg;

  localparam int unsigned CNT_W = 64;
  localparam int unsigned RD_W  = 32;
  localparam logic [RD_W-1:0] ERR_DATA = 32'h0;

  typedef enum logic [1:0] {
    IDLE,
    SEND_LO,
    SEND_HI,
    SEND_ERR
  } perf_rd_state_t;

endpackage

// File: rtl/perf_count_reader.sv
// perf_count_reader: snapshots one 64-bit event counter atomically on request
// and returns it as two 32-bit beats (low word first) on a valid/ready stream.
// Optionally pulses a one-hot clear back to the selected counter.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   cnt_in               counter i occupies [64*i+63 : 64*i]
//   req_valid/req_ready  request handshake; req_idx selects counter,
//                        req_clear requests read-and-clear
//   clr_out              one-hot clear pulse, one cycle, ORed into counter rst
//   rd_valid/rd_ready    response beat handshake
//   rd_data, rd_last     beat payload and final-beat marker
//   rd_err               request index was out of range (single zero beat)
module perf_count_reader
  import perf_count_reader_pkg::*;
#(
  parameter int NUM_CNT = 4,
  parameter int IDX_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CNT*CNT_W-1:0] cnt_in,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [IDX_W-1:0]         req_idx,
  input  logic                     req_clear,
  output logic [NUM_CNT-1:0]       clr_out,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [RD_W-1:0]          rd_data,
  output logic                     rd_last,
  output logic                     rd_err
);

  localparam logic [IDX_W:0] NUM_CNT_L = (IDX_W+1)'(NUM_CNT);

  perf_rd_state_t       state_q, state_d;
  logic [CNT_W-1:0]     snap_q;
  logic [NUM_CNT-1:0]   clr_q;
  logic                 idx_ok;
  logic                 accept;
  logic [CNT_W-1:0]     sel_cnt;

  assign idx_ok  = {1'b0, req_idx} < NUM_CNT_L;
  assign accept  = (state_q == IDLE) && req_valid;
  // Only consumed when idx_ok, so an out-of-range select is never used.
  assign sel_cnt = cnt_in[CNT_W*int'(req_idx) +: CNT_W];
  assign clr_out = clr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      // Clear is registered on acceptance, so it is high for exactly the
      // first SEND_LO cycle regardless of stalls on that beat.
      clr_q   <= '0;
      if (accept && idx_ok) begin
        snap_q <= sel_cnt;
        if (req_clear) begin
          clr_q <= NUM_CNT'(1) << req_idx;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = '0;
    rd_last   = 1'b0;
    rd_err    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = idx_ok ? SEND_LO : SEND_ERR;
        end
      end
      SEND_LO: begin
        rd_valid = 1'b1;
        rd_data  = snap_q[RD_W-1:0];
        if (rd_ready) state_d = SEND_HI;
      end
      SEND_HI: begin
        rd_valid = 1'b1;
        rd_data  = snap_q[CNT_W-1:RD_W];
        rd_last  = 1'b1;
        if (rd_ready) state_d = IDLE;
      end
      SEND_ERR: begin
        rd_valid = 1'b1;
        rd_data  = ERR_DATA;
        rd_last  = 1'b1;
        rd_err   = 1'b1;
        if (rd_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
